control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
Microcoded-style Moore FSM that sequences the 32-bit datapath: generates every register/bus/ALU control strobe from the current step and the opcode field of the instruction register. Sits directly upstream of the datapath; consumes IR and CON_FF back from it, drives Clear/Run to the system. Fetch takes three steps T0-T2, execute takes up to five steps T3-T7, then control returns to T0.

Parameters:
MEM_WAIT, 0, extra cycles (0-7) that each memory step (fetch T1, load T6, store T7) is held with Read/Write asserted.

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
IR  in  32  instruction register; opcode = IR[31:27]
CON_FF  in  1  branch-condition flag from datapath
Stop  in  1  level request to pause before the next fetch
PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, BAout, Cout  out  1 each  bus-drive selects
MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin  out  1 each  register load enables
Gra, Grb, Grc, Rin, Rout  out  1 each  register-file field select / read / write
IncPC, Read, Write  out  1 each  PC increment, memory read, memory write
AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT  out  1 each  one-hot ALU operation
Run  out  1  high while executing
Clear  out  1  datapath clear pulse

Behaviour:
- States: RST, T0..T7, HALT. Outputs decoded combinationally from state and IR[31:27] (Moore w.r.t. IR); any strobe not listed for a step is 0.
- Reset low (any time, incl. mid-instruction/mid-wait): state=RST, wait counter=0, all strobes 0, Run=0, Clear=1. First edge after release: RST->T0, Clear=0, Run=1.
- Fetch: T0 PCout MARin IncPC Zin | T1 Zlowout PCin Read MDRin | T2 MDRout IRin.
- Wait: in a memory step, counter counts 0..MEM_WAIT; step advances on the edge where counter==MEM_WAIT; strobes held constant throughout; counter clears on advance. MEM_WAIT=0 -> one cycle per step.
- Opcodes / execute steps (last step -> T0):
  add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010: T3 Grb Rout Yin | T4 Grc Rout op Zin | T5 Zlowout Gra Rin.
  addi 01011 (ADD), andi 01100 (AND), ori 01101 (OR): T3 Grb Rout Yin | T4 Cout op Zin | T5 Zlowout Gra Rin.
  mul 01110, div 01111: T3 Gra Rout Yin | T4 Grb Rout op Zin | T5 Zlowout LOin | T6 Zhighout HIin.
  neg 10000, not 10001: T3 Grb Rout op Zin | T4 Zlowout Gra Rin.
  ldi 00001: T3 Grb BAout Yin | T4 Cout ADD Zin | T5 Zlowout Gra Rin.
  ld 00000: ldi T3-T4 | T5 Zlowout MARin | T6 Read MDRin | T7 MDRout Gra Rin.
  st 00010: ldi T3-T4 | T5 Zlowout MARin | T6 Gra Rout MDRin | T7 Write.
  br 10010: T3 Gra Rout CONin | T4 PCout Yin | T5 Cout ADD Zin | T6 Zlowout, PCin only if CON_FF=1.
  jr 10011: T3 Gra Rout PCin. in 10101: T3 InPortout Gra Rin. out 10110: T3 Gra Rout OutPortin. mfhi 10111: T3 HIout Gra Rin. mflo 11000: T3 LOout Gra Rin.
  nop 11001: T2 -> T0. halt 11010: T2 -> HALT (sticky until Reset).
  Other opcodes: as nop.
- Stop: evaluated on every transition into T0 (not from RST). If Stop=1, go to HALT instead; Stop-caused HALT returns to T0 on the first edge with Stop=0. An instruction in progress always completes.
- HALT: all strobes 0, Run=0, Clear=0.
- At most one ALU op strobe high in any cycle.

Optional Feature:
CU_ILLEGAL_TRAP_EN: adds output IllegalOp (1 bit). Defined: an opcode not listed above, sampled at T2, sends the FSM to HALT (sticky, like halt) and sets IllegalOp=1 until Reset; Reset clears IllegalOp to 0. Undefined: such opcodes execute as nop and the port does not exist.

Test Plan:
Reset low 3 cycles, release, IR=add (0x18000000|fields), MEM_WAIT=0 -> Clear=1 in RST, T0 strobes on next edge, Grc Rout ADD Zin in cycle 5, back in T0 at cycle 7.
MEM_WAIT=2, ld instruction -> Read+MDRin held exactly 3 cycles in T1 and in T6; total instruction length 12 cycles.
br with CON_FF=0 then CON_FF=1 -> PCin=0 in T6 for first, PCin=1 with Zlowout in T6 for second; CONin high only in T3.
mul -> LOin in T5, HIin in T6, MUL high only in T4; halt opcode -> Run=0 permanently until Reset pulse, then restarts at T0.
Stop raised during T4 of sub -> sub completes through T5, FSM in HALT; Stop dropped -> T0 next edge, Run=1.
Reset asserted mid-T1 wait with MEM_WAIT=3 -> immediately RST, Read=0; after release fetch restarts with full 4-cycle T1.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: Moore FSM sequencing the 32-bit datapath (fetch T0-T2, execute T3-T7, memory steps stretched by MEM_WAIT).
// Optional define CU_ILLEGAL_TRAP_EN: undefined opcodes trap into a sticky HALT and raise IllegalOp.
module control_unit #(
   parameter int MEM_WAIT = 0
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   input  logic        Stop,
   output logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, BAout, Cout,
   output logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin,
   output logic        Gra, Grb, Grc, Rin, Rout,
   output logic        IncPC, Read, Write,
   output logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT,
   output logic        Run,
   output logic        Clear
`ifdef CU_ILLEGAL_TRAP_EN
   , output logic      IllegalOp
`endif
);
   typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
   localparam logic [2:0] MW = 3'(MEM_WAIT);
   state_t state, nxt;
   logic [2:0] cnt, cnt_n;
   logic sticky, sticky_n;
   logic [4:0] op;
   logic t0, t1, t2, t3, t4, t5, t6, t7;
   logic alu3, imm, md, nn, ldi, ld, st, br, jr, inp, outp, mfhi, mflo, halt;
   logic exec, ex4, mem, adv, last, trap;
   logic unused_ir;
   assign op = IR[31:27];
   assign unused_ir = ^IR[26:0];
   assign t0 = state == T0;
   assign t1 = state == T1;
   assign t2 = state == T2;
   assign t3 = state == T3;
   assign t4 = state == T4;
   assign t5 = state == T5;
   assign t6 = state == T6;
   assign t7 = state == T7;
   assign alu3 = op >= 5'd3 && op <= 5'd10;
   assign imm = op >= 5'd11 && op <= 5'd13;
   assign md = op == 5'd14 || op == 5'd15;
   assign nn = op == 5'd16 || op == 5'd17;
   assign ld = op == 5'd0;
   assign ldi = op == 5'd1;
   assign st = op == 5'd2;
   assign br = op == 5'd18;
   assign jr = op == 5'd19;
   assign inp = op == 5'd21;
   assign outp = op == 5'd22;
   assign mfhi = op == 5'd23;
   assign mflo = op == 5'd24;
   assign halt = op == 5'd26;
`ifdef CU_ILLEGAL_TRAP_EN
   assign trap = op == 5'd20 || op >= 5'd27;
`else
   assign trap = 1'b0;
`endif
   assign exec = alu3 | imm | md | nn | ldi | ld | st | br | jr | inp | outp | mfhi | mflo;
   assign ex4 = t4 & (alu3 | imm | md);
   assign mem = t1 | (t6 & ld) | (t7 & st);
   assign adv = !mem || cnt == MW;
   // Final execute step of each instruction class; T7 always ends an instruction.
   assign last = (t3 & (jr | inp | outp | mfhi | mflo)) | (t4 & nn) | (t5 & (alu3 | imm | ldi))
               | (t6 & (md | br)) | t7;
   always_comb begin
      nxt = state;
      cnt_n = 3'd0;
      sticky_n = sticky;
      case (state)
         RST: nxt = T0;
         HALT: nxt = sticky || Stop ? HALT : T0;
         T2: begin
            nxt = halt || trap ? HALT : exec ? T3 : Stop ? HALT : T0;
            sticky_n = sticky | halt | trap;
         end
         default: begin
            cnt_n = adv ? 3'd0 : cnt + 3'd1;
            nxt = !adv ? state : last ? (Stop ? HALT : T0) : state_t'(state + 4'd1);
         end
      endcase
   end
   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) begin
         state <= RST;
         cnt <= 3'd0;
         sticky <= 1'b0;
      end else begin
         state <= nxt;
         cnt <= cnt_n;
         sticky <= sticky_n;
      end
`ifdef CU_ILLEGAL_TRAP_EN
   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) IllegalOp <= 1'b0;
      else if (t2 && trap) IllegalOp <= 1'b1;
`endif
   assign PCout = t0 | (t4 & br);
   assign Zhighout = t6 & md;
   assign Zlowout = t1 | (t5 & (alu3 | imm | md | ldi | ld | st)) | (t4 & nn) | (t6 & br);
   assign MDRout = t2 | (t7 & ld);
   assign HIout = t3 & mfhi;
   assign LOout = t3 & mflo;
   assign InPortout = t3 & inp;
   assign BAout = t3 & (ldi | ld | st);
   assign Cout = (t4 & (imm | ldi | ld | st)) | (t5 & br);
   assign MARin = t0 | (t5 & (ld | st));
   assign Zin = t0 | (t4 & (alu3 | imm | md | ldi | ld | st)) | (t3 & nn) | (t5 & br);
   assign PCin = t1 | (t3 & jr) | (t6 & br & CON_FF);
   assign MDRin = t1 | (t6 & (ld | st));
   assign IRin = t2;
   assign Yin = (t3 & (alu3 | imm | md | ldi | ld | st)) | (t4 & br);
   assign HIin = t6 & md;
   assign LOin = t5 & md;
   assign OutPortin = t3 & outp;
   assign CONin = t3 & br;
   assign Gra = (t5 & (alu3 | imm | ldi)) | (t3 & (md | br | jr | inp | outp | mfhi | mflo))
              | (t4 & nn) | (t7 & ld) | (t6 & st);
   assign Grb = (t3 & (alu3 | imm | ldi | ld | st | nn)) | (t4 & md);
   assign Grc = t4 & alu3;
   assign Rin = (t5 & (alu3 | imm | ldi)) | (t4 & nn) | (t7 & ld) | (t3 & (inp | mfhi | mflo));
   assign Rout = (t3 & (alu3 | imm | md | nn | br | jr | outp)) | (t4 & (alu3 | md)) | (t6 & st);
   assign IncPC = t0;
   assign Read = t1 | (t6 & ld);
   assign Write = t7 & st;
   assign ADD = (ex4 & (op == 5'd3 || op == 5'd11)) | (t4 & (ldi | ld | st)) | (t5 & br);
   assign SUB = ex4 & (op == 5'd4);
   assign SHR = ex4 & (op == 5'd5);
   assign SHL = ex4 & (op == 5'd6);
   assign ROR = ex4 & (op == 5'd7);
   assign ROL = ex4 & (op == 5'd8);
   assign AND = ex4 & (op == 5'd9 || op == 5'd12);
   assign OR = ex4 & (op == 5'd10 || op == 5'd13);
   assign MUL = ex4 & (op == 5'd14);
   assign DIV = ex4 & (op == 5'd15);
   assign NEG = t3 & (op == 5'd16);
   assign NOT = t3 & (op == 5'd17);
   assign Run = state != RST && state != HALT;
   assign Clear = state == RST;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed tables plus randomized run against an instruction-level model, on MEM_WAIT = 0, 2, 3.
module tb_control_unit;
   localparam int NI = 3;
   localparam logic [40:0] PCO = 41'd1 << 0, ZHO = 41'd1 << 1, ZLO = 41'd1 << 2, MDRO = 41'd1 << 3,
      HIO = 41'd1 << 4, LOO = 41'd1 << 5, INPO = 41'd1 << 6, BAO = 41'd1 << 7, COUT = 41'd1 << 8,
      MARIN = 41'd1 << 9, ZIN = 41'd1 << 10, PCIN = 41'd1 << 11, MDRIN = 41'd1 << 12, IRIN = 41'd1 << 13,
      YIN = 41'd1 << 14, HIIN = 41'd1 << 15, LOIN = 41'd1 << 16, OUTIN = 41'd1 << 17, CONIN = 41'd1 << 18,
      GRA = 41'd1 << 19, GRB = 41'd1 << 20, GRC = 41'd1 << 21, RIN = 41'd1 << 22, ROUT = 41'd1 << 23,
      INC = 41'd1 << 24, READ = 41'd1 << 25, WRITE = 41'd1 << 26,
      A_AND = 41'd1 << 27, A_OR = 41'd1 << 28, A_ADD = 41'd1 << 29, A_SUB = 41'd1 << 30, A_MUL = 41'd1 << 31,
      A_DIV = 41'd1 << 32, A_SHR = 41'd1 << 33, A_SHL = 41'd1 << 34, A_ROR = 41'd1 << 35, A_ROL = 41'd1 << 36,
      A_NEG = 41'd1 << 37, A_NOT = 41'd1 << 38, R = 41'd1 << 39, CLR = 41'd1 << 40;
   localparam logic [40:0] F0 = PCO | MARIN | INC | ZIN, F1 = ZLO | PCIN | READ | MDRIN, F2 = MDRO | IRIN;
   localparam logic [4:0] OLD = 5'd0, OADD = 5'd3, OSUB = 5'd4, OMUL = 5'd14, ONEG = 5'd16, OBR = 5'd18,
      ONOP = 5'd25, OHALT = 5'd26;
`ifdef CU_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   typedef struct {
      logic rst;
      logic [4:0] op;
      logic stop;
      logic con;
      logic [40:0] exp;
   } vec_t;
   logic Clock = 1'b0, Reset = 1'b0, con = 1'b0, stop = 1'b0;
   logic [31:0] ir [NI];
   wire [40:0] o [NI];
   wire ill [NI];
   int checks = 0, errors = 0;
   vec_t tv [$];
   int ms [NI], mk [NI], mw [NI];
   bit msk [NI], mil [NI];
   always #5 Clock = ~Clock;
   for (genvar g = 0; g < NI; g++) begin : u
      control_unit #(.MEM_WAIT(g == 0 ? 0 : g + 1)) dut (
         .Clock(Clock), .Reset(Reset), .IR(ir[g]), .CON_FF(con), .Stop(stop),
         .PCout(o[g][0]), .Zhighout(o[g][1]), .Zlowout(o[g][2]), .MDRout(o[g][3]), .HIout(o[g][4]),
         .LOout(o[g][5]), .InPortout(o[g][6]), .BAout(o[g][7]), .Cout(o[g][8]),
         .MARin(o[g][9]), .Zin(o[g][10]), .PCin(o[g][11]), .MDRin(o[g][12]), .IRin(o[g][13]),
         .Yin(o[g][14]), .HIin(o[g][15]), .LOin(o[g][16]), .OutPortin(o[g][17]), .CONin(o[g][18]),
         .Gra(o[g][19]), .Grb(o[g][20]), .Grc(o[g][21]), .Rin(o[g][22]), .Rout(o[g][23]),
         .IncPC(o[g][24]), .Read(o[g][25]), .Write(o[g][26]),
         .AND(o[g][27]), .OR(o[g][28]), .ADD(o[g][29]), .SUB(o[g][30]), .MUL(o[g][31]), .DIV(o[g][32]),
         .SHR(o[g][33]), .SHL(o[g][34]), .ROR(o[g][35]), .ROL(o[g][36]), .NEG(o[g][37]), .NOT(o[g][38]),
         .Run(o[g][39]), .Clear(o[g][40])
`ifdef CU_ILLEGAL_TRAP_EN
         , .IllegalOp(ill[g])
`endif
      );
`ifndef CU_ILLEGAL_TRAP_EN
      assign ill[g] = 1'b0;
`endif
   end
   task automatic chk(input string nm, input logic [40:0] a, input logic [40:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, a, e);
      end
   endtask
   task automatic row(input logic rs, input logic [4:0] op, input logic sp, input logic cn, input logic [40:0] e);
      vec_t v;
      v.rst = rs; v.op = op; v.stop = sp; v.con = cn; v.exp = e;
      tv.push_back(v);
   endtask
   // Microprogram listed per instruction: strobes of step k (0..7), excluding Run.
   function automatic logic [40:0] micro(input logic [4:0] op, input int k, input logic c);
      logic [40:0] f;
      case (op)
         3, 11: f = A_ADD;
         4: f = A_SUB;
         5: f = A_SHR;
         6: f = A_SHL;
         7: f = A_ROR;
         8: f = A_ROL;
         9, 12: f = A_AND;
         10, 13: f = A_OR;
         14: f = A_MUL;
         15: f = A_DIV;
         16: f = A_NEG;
         17: f = A_NOT;
         default: f = '0;
      endcase
      if (k == 0) return F0;
      if (k == 1) return F1;
      if (k == 2) return F2;
      case (op)
         3, 4, 5, 6, 7, 8, 9, 10: return k == 3 ? GRB | ROUT | YIN : k == 4 ? GRC | ROUT | f | ZIN : k == 5 ? ZLO | GRA | RIN : '0;
         11, 12, 13: return k == 3 ? GRB | ROUT | YIN : k == 4 ? COUT | f | ZIN : k == 5 ? ZLO | GRA | RIN : '0;
         14, 15: return k == 3 ? GRA | ROUT | YIN : k == 4 ? GRB | ROUT | f | ZIN : k == 5 ? ZLO | LOIN : k == 6 ? ZHO | HIIN : '0;
         16, 17: return k == 3 ? GRB | ROUT | f | ZIN : k == 4 ? ZLO | GRA | RIN : '0;
         1: return k == 3 ? GRB | BAO | YIN : k == 4 ? COUT | A_ADD | ZIN : k == 5 ? ZLO | GRA | RIN : '0;
         0: return k == 3 ? GRB | BAO | YIN : k == 4 ? COUT | A_ADD | ZIN : k == 5 ? ZLO | MARIN : k == 6 ? READ | MDRIN : k == 7 ? MDRO | GRA | RIN : '0;
         2: return k == 3 ? GRB | BAO | YIN : k == 4 ? COUT | A_ADD | ZIN : k == 5 ? ZLO | MARIN : k == 6 ? GRA | ROUT | MDRIN : k == 7 ? WRITE : '0;
         18: return k == 3 ? GRA | ROUT | CONIN : k == 4 ? PCO | YIN : k == 5 ? COUT | A_ADD | ZIN : k == 6 ? ZLO | (c ? PCIN : '0) : '0;
         19: return k == 3 ? GRA | ROUT | PCIN : '0;
         21: return k == 3 ? INPO | GRA | RIN : '0;
         22: return k == 3 ? GRA | ROUT | OUTIN : '0;
         23: return k == 3 ? HIO | GRA | RIN : '0;
         24: return k == 3 ? LOO | GRA | RIN : '0;
         default: return '0;
      endcase
   endfunction
   function automatic int nexec(input logic [4:0] op);
      case (op)
         1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13: return 3;
         14, 15, 18: return 4;
         16, 17: return 2;
         0, 2: return 5;
         19, 21, 22, 23, 24: return 1;
         default: return 0;
      endcase
   endfunction
   function automatic logic [40:0] expv(input int g);
      return ms[g] == 0 ? CLR : ms[g] == 2 ? 41'd0 : R | micro(ir[g][31:27], mk[g], con);
   endfunction
   function automatic logic [4:0] pick_op();
      int v;
      if ($urandom_range(7) == 0) return 5'($urandom_range(31));
      v = $urandom_range(24);
      return 5'(v >= 20 ? v + 1 : v);
   endfunction
   // Model states: 0 reset, 1 running (step mk, wait count mw), 2 halted.
   task automatic mstep(input int g);
      logic [4:0] op;
      int n, w;
      op = ir[g][31:27];
      n = nexec(op);
      w = g == 0 ? 0 : g + 1;
      if (ms[g] == 0) begin
         ms[g] = 1; mk[g] = 0;
      end else if (ms[g] == 2) begin
         if (!msk[g] && !stop) begin ms[g] = 1; mk[g] = 0; end
      end else if ((mk[g] == 1 || (mk[g] == 6 && op == 0) || (mk[g] == 7 && op == 2)) && mw[g] != w) begin
         mw[g]++;
      end else begin
         mw[g] = 0;
         if (mk[g] == 2 && (op == OHALT || (TRAP && (op == 20 || op >= 27)))) begin
            ms[g] = 2; msk[g] = 1'b1; mil[g] = mil[g] | (op != OHALT);
         end else if (mk[g] == 2 + n) begin
            ms[g] = stop ? 2 : 1; mk[g] = 0;
         end else mk[g]++;
      end
   endtask
   task automatic do_reset();
      @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);
      Reset = 1'b1;
   endtask
   initial begin
      logic [40:0] sa [13];
      logic [40:0] sb [7];
      for (int g = 0; g < NI; g++) ir[g] = 32'h0;
      repeat (3) row(0, OADD, 0, 0, CLR);
      row(1, OADD, 0, 0, CLR);
      row(1, OADD, 0, 0, R | F0); row(1, OADD, 0, 0, R | F1); row(1, OADD, 0, 0, R | F2);
      row(1, OADD, 0, 0, R | GRB | ROUT | YIN); row(1, OADD, 0, 0, R | GRC | ROUT | A_ADD | ZIN);
      row(1, OADD, 0, 0, R | ZLO | GRA | RIN);
      row(1, OBR, 0, 0, R | F0); row(1, OBR, 0, 0, R | F1); row(1, OBR, 0, 0, R | F2);
      row(1, OBR, 0, 0, R | GRA | ROUT | CONIN); row(1, OBR, 0, 0, R | PCO | YIN);
      row(1, OBR, 0, 0, R | COUT | A_ADD | ZIN); row(1, OBR, 0, 0, R | ZLO);
      row(1, OBR, 0, 1, R | F0); row(1, OBR, 0, 1, R | F1); row(1, OBR, 0, 1, R | F2);
      row(1, OBR, 0, 1, R | GRA | ROUT | CONIN); row(1, OBR, 0, 1, R | PCO | YIN);
      row(1, OBR, 0, 1, R | COUT | A_ADD | ZIN); row(1, OBR, 0, 1, R | ZLO | PCIN);
      row(1, OMUL, 0, 0, R | F0); row(1, OMUL, 0, 0, R | F1); row(1, OMUL, 0, 0, R | F2);
      row(1, OMUL, 0, 0, R | GRA | ROUT | YIN); row(1, OMUL, 0, 0, R | GRB | ROUT | A_MUL | ZIN);
      row(1, OMUL, 0, 0, R | ZLO | LOIN); row(1, OMUL, 0, 0, R | ZHO | HIIN);
      row(1, OSUB, 0, 0, R | F0); row(1, OSUB, 0, 0, R | F1); row(1, OSUB, 0, 0, R | F2);
      row(1, OSUB, 0, 0, R | GRB | ROUT | YIN); row(1, OSUB, 1, 0, R | GRC | ROUT | A_SUB | ZIN);
      row(1, OSUB, 1, 0, R | ZLO | GRA | RIN); row(1, OSUB, 1, 0, 41'd0); row(1, OSUB, 0, 0, 41'd0);
      row(1, OHALT, 0, 0, R | F0); row(1, OHALT, 0, 0, R | F1); row(1, OHALT, 0, 0, R | F2);
      repeat (3) row(1, OHALT, 0, 0, 41'd0);
      row(0, ONOP, 0, 0, CLR); row(1, ONOP, 0, 0, CLR);
      row(1, ONOP, 0, 0, R | F0); row(1, ONOP, 0, 0, R | F1); row(1, ONOP, 0, 0, R | F2);
      row(1, ONEG, 0, 0, R | F0); row(1, ONEG, 0, 0, R | F1); row(1, ONEG, 0, 0, R | F2);
      row(1, ONEG, 0, 0, R | GRB | ROUT | A_NEG | ZIN); row(1, ONEG, 0, 0, R | ZLO | GRA | RIN);
      row(1, ONOP, 0, 0, R | F0);
      foreach (tv[i]) begin
         @(negedge Clock);
         Reset = tv[i].rst; stop = tv[i].stop; con = tv[i].con;
         for (int g = 0; g < NI; g++) ir[g] = {tv[i].op, 27'h12345};
         #1 chk($sformatf("table row %0d", i), o[0], tv[i].exp);
      end
      stop = 1'b0; con = 1'b0;
      for (int g = 0; g < NI; g++) ir[g] = {OLD, 27'h0};
      sa = '{R | F0, R | F1, R | F1, R | F1, R | F2, R | GRB | BAO | YIN, R | COUT | A_ADD | ZIN,
             R | ZLO | MARIN, R | READ | MDRIN, R | READ | MDRIN, R | READ | MDRIN, R | MDRO | GRA | RIN, R | F0};
      do_reset();
      #1 chk("ld wait2 reset", o[1], CLR);
      for (int i = 0; i < 13; i++) begin
         @(negedge Clock);
         #1 chk($sformatf("ld wait2 cycle %0d", i), o[1], sa[i]);
      end
      for (int g = 0; g < NI; g++) ir[g] = {OADD, 27'h0};
      do_reset();
      #1 chk("wait3 reset", o[2], CLR);
      @(negedge Clock);
      #1 chk("wait3 T0", o[2], R | F0);
      repeat (2) begin
         @(negedge Clock);
         #1 chk("wait3 T1", o[2], R | F1);
      end
      @(negedge Clock);
      Reset = 1'b0;
      #1 chk("wait3 async reset mid T1", o[2], CLR);
      @(negedge Clock);
      Reset = 1'b1;
      #1 chk("wait3 released", o[2], CLR);
      sb = '{R | F0, R | F1, R | F1, R | F1, R | F1, R | F2, R | GRB | ROUT | YIN};
      for (int i = 0; i < 7; i++) begin
         @(negedge Clock);
         #1 chk($sformatf("wait3 refetch %0d", i), o[2], sb[i]);
      end
      for (int c = 0; c < 3000; c++) begin
         @(negedge Clock);
         Reset = c == 0 ? 1'b0 : ($urandom_range(63) != 0);
         stop = $urandom_range(7) == 0;
         con = 1'($urandom);
         for (int g = 0; g < NI; g++) begin
            if (!Reset) begin ms[g] = 0; mk[g] = 0; mw[g] = 0; msk[g] = 1'b0; mil[g] = 1'b0; end
            if (ms[g] != 1 || mk[g] == 0) ir[g] = {pick_op(), 27'($urandom)};
         end
         #1;
         for (int g = 0; g < NI; g++) begin
            chk($sformatf("random c%0d unit%0d", c, g), o[g], expv(g));
            if (TRAP) chk($sformatf("illegal c%0d unit%0d", c, g), {40'd0, ill[g]}, {40'd0, mil[g]});
         end
         for (int g = 0; g < NI; g++) if (Reset) mstep(g);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
